weight_ram_ctrl: RTL

- Controller owning the single shared port of the float16 weight RAM (WeightRamFloat16).
- LOAD phase: accepts kernel slices (KS_MAX*KS_MAX float16 words each) on a valid/ready stream and writes one slice per cycle.
- READ phase: streams the stored weights to the conv datapath one float16 per cycle, in slice-major, element-minor order, with backpressure.
- Arbitrates ena_wr so that load and read never overlap.

---
 rtl/weight_ram_pkg.sv | 40 ++++
 rtl/weight_read_seq.sv | 140 ++++++++++++++
 rtl/weight_ram_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/weight_ram_pkg.sv
// Shared constants, state encoding and config clamping for the float16 weight RAM controller.
package weight_ram_pkg;

    localparam int unsigned DATA_WIDTH              = 16;
    localparam int unsigned KERNEL_SIZE_MAX         = 3;
    localparam int unsigned WEIGHT_RAM_MAX          = 1152;
    localparam int unsigned WEIGHT_WRITE_ADDR_WIDTH = 7;
    localparam int unsigned WEIGHT_READ_ADDR_WIDTH  = 11;

    localparam int unsigned KS_SQ_MAX          = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int unsigned SLICE_MAX          = WEIGHT_RAM_MAX / KS_SQ_MAX;
    localparam int unsigned SLICE_DATA_WIDTH   = KS_SQ_MAX * DATA_WIDTH;
    localparam int unsigned NUM_SLICES_WIDTH   = WEIGHT_WRITE_ADDR_WIDTH + 1;
    localparam int unsigned KS_WIDTH           = 4;
    localparam int unsigned ELEM_WIDTH         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_e;

    // Out-of-range kernel edges fall back to the largest supported kernel.
    function automatic logic [KS_WIDTH-1:0] clamp_ks(input logic [KS_WIDTH-1:0] ks);
        if ((ks == '0) || (ks > KS_WIDTH'(KERNEL_SIZE_MAX))) begin
            return KS_WIDTH'(KERNEL_SIZE_MAX);
        end
        return ks;
    endfunction

    function automatic logic [NUM_SLICES_WIDTH-1:0] clamp_num_slices(
        input logic [NUM_SLICES_WIDTH-1:0] n
    );
        if (n > NUM_SLICES_WIDTH'(SLICE_MAX)) begin
            return NUM_SLICES_WIDTH'(SLICE_MAX);
        end
        return n;
    endfunction

endpackage

// File: rtl/weight_read_seq.sv
// Read-side address sequencer: slice/elem counters, one-cycle RAM latency tracking
// and a one-entry skid register so backpressure never loses or repeats a weight.
module weight_read_seq
    import weight_ram_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [KS_WIDTH-1:0]               ks_i,
    input  logic [NUM_SLICES_WIDTH-1:0]       num_slices_i,
    input  logic                              out_ready_i,
    input  logic [DATA_WIDTH-1:0]             ram_dout_i,
    output logic [WEIGHT_READ_ADDR_WIDTH-1:0] ram_addr_read_o,
    output logic                              out_valid_o,
    output logic [DATA_WIDTH-1:0]             out_data_o,
    output logic                              out_last_o,
    output logic                              done_o
);

    logic                               active_q, active_d;
    logic                               pend_q, pend_d;
    logic [WEIGHT_READ_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WEIGHT_READ_ADDR_WIDTH-1:0]  base_q, base_d;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] slice_q, slice_d;
    logic [ELEM_WIDTH-1:0]              elem_q, elem_d;
    logic                               rd_valid_q, rd_valid_d;
    logic                               rd_last_q, rd_last_d;
    logic                               skid_valid_q, skid_valid_d;
    logic                               skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0]              skid_data_q, skid_data_d;

    logic [ELEM_WIDTH-1:0] ks_sq;
    logic                  elem_last;
    logic                  slice_last;
    logic                  addr_is_last;
    logic                  accept;
    logic                  rd_leaves;
    logic                  rd_stays;
    logic                  skid_capture;
    logic                  advance;

    assign ks_sq        = ELEM_WIDTH'(ks_i * ks_i);
    assign elem_last    = (elem_q == (ks_sq - ELEM_WIDTH'(1)));
    assign slice_last   = ({1'b0, slice_q} == (num_slices_i - NUM_SLICES_WIDTH'(1)));
    assign addr_is_last = elem_last & slice_last;

    assign ram_addr_read_o = addr_q;
    assign out_valid_o     = skid_valid_q | rd_valid_q;
    assign out_data_o      = skid_valid_q ? skid_data_q : ram_dout_i;
    assign out_last_o      = skid_valid_q ? skid_last_q : rd_last_q;
    assign accept          = out_valid_o & out_ready_i;
    assign done_o          = accept & out_last_o;

    // pend_q marks the first cycle an address is presented; a held address re-reads
    // the same word, so RAM dout stays stable while the skid register is occupied.
    always_comb begin
        active_d     = active_q;
        pend_d       = 1'b0;
        addr_d       = addr_q;
        base_d       = base_q;
        slice_d      = slice_q;
        elem_d       = elem_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;

        rd_leaves    = rd_valid_q & ~skid_valid_q;
        rd_stays     = rd_valid_q & skid_valid_q;
        skid_capture = rd_leaves & ~out_ready_i;

        skid_valid_d = skid_valid_q ? ~accept : skid_capture;
        if (skid_capture) begin
            skid_data_d = ram_dout_i;
            skid_last_d = rd_last_q;
        end

        rd_valid_d = rd_stays | pend_q;
        rd_last_d  = rd_stays ? rd_last_q : addr_is_last;

        advance = active_q & ~addr_is_last & ~skid_valid_d;
        if (advance) begin
            pend_d = 1'b1;
            if (elem_last) begin
                elem_d  = '0;
                slice_d = slice_q + WEIGHT_WRITE_ADDR_WIDTH'(1);
                base_d  = base_q + WEIGHT_READ_ADDR_WIDTH'(KS_SQ_MAX);
                addr_d  = base_q + WEIGHT_READ_ADDR_WIDTH'(KS_SQ_MAX);
            end else begin
                elem_d = elem_q + ELEM_WIDTH'(1);
                addr_d = addr_q + WEIGHT_READ_ADDR_WIDTH'(1);
            end
        end

        if (done_o) begin
            active_d     = 1'b0;
            pend_d       = 1'b0;
            rd_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end

        if (start_i) begin
            active_d     = 1'b1;
            pend_d       = 1'b1;
            addr_d       = '0;
            base_d       = '0;
            slice_d      = '0;
            elem_d       = '0;
            rd_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q     <= 1'b0;
            pend_q       <= 1'b0;
            addr_q       <= '0;
            base_q       <= '0;
            slice_q      <= '0;
            elem_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            active_q     <= active_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            slice_q      <= slice_d;
            elem_q       <= elem_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/weight_ram_ctrl.sv
// Owner of the shared weight RAM port: loads kernel slices (one per cycle) and
// streams stored weights back to the conv datapath, never both at once.
module weight_ram_ctrl
    import weight_ram_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [KS_WIDTH-1:0]                 cfg_ks,
    input  logic [NUM_SLICES_WIDTH-1:0]         cfg_num_slices,
    input  logic                                start_load,
    input  logic                                start_read,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SLICE_DATA_WIDTH-1:0]         in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic                                load_done,
    output logic                                read_done,
    output logic                                ram_ena_wr,
    output logic [WEIGHT_WRITE_ADDR_WIDTH-1:0]  ram_addr_write,
    output logic [SLICE_DATA_WIDTH-1:0]         ram_din,
    output logic [WEIGHT_READ_ADDR_WIDTH-1:0]   ram_addr_read,
    input  logic [DATA_WIDTH-1:0]               ram_dout
);

    state_e state_q, state_d;

    logic [KS_WIDTH-1:0]                ks_q;
    logic [NUM_SLICES_WIDTH-1:0]        num_slices_q;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] wr_cnt_q;
    logic                               load_done_q;
    logic                               read_done_q;

    logic [KS_WIDTH-1:0]         ks_clamp;
    logic [NUM_SLICES_WIDTH-1:0] ns_clamp;
    logic                        idle;
    logic                        go_load;
    logic                        go_read;
    logic                        ns_zero;
    logic                        wr_beat;
    logic                        wr_last;
    logic                        seq_start;
    logic                        seq_done;

    assign ks_clamp  = clamp_ks(cfg_ks);
    assign ns_clamp  = clamp_num_slices(cfg_num_slices);
    assign idle      = (state_q == ST_IDLE);
    // LOAD wins a same-cycle collision; start_read is simply dropped.
    assign go_load   = idle & start_load;
    assign go_read   = idle & start_read & ~start_load;
    assign ns_zero   = (ns_clamp == '0);
    assign wr_beat   = (state_q == ST_LOAD) & in_valid;
    assign wr_last   = ({1'b0, wr_cnt_q} == (num_slices_q - NUM_SLICES_WIDTH'(1)));
    assign seq_start = go_read & ~ns_zero;

    assign busy           = ~idle;
    assign load_done      = load_done_q;
    assign read_done      = read_done_q;
    assign ram_din        = in_data;
    assign ram_addr_write = wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_load && !ns_zero) begin
                    state_d = ST_LOAD;
                end else if (seq_start) begin
                    state_d = ST_READ;
                end
            end
            ST_LOAD: begin
                if (wr_beat && wr_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (seq_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        ram_ena_wr = 1'b0;
        if (state_q == ST_LOAD) begin
            in_ready   = 1'b1;
            ram_ena_wr = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ks_q         <= '0;
            num_slices_q <= '0;
            wr_cnt_q     <= '0;
            load_done_q  <= 1'b0;
            read_done_q  <= 1'b0;
        end else begin
            load_done_q <= (go_load & ns_zero) | (wr_beat & wr_last);
            read_done_q <= (go_read & ns_zero) | ((state_q == ST_READ) & seq_done);
            if (go_load || go_read) begin
                ks_q         <= ks_clamp;
                num_slices_q <= ns_clamp;
            end
            if (go_load) begin
                wr_cnt_q <= '0;
            end else if (wr_beat) begin
                wr_cnt_q <= wr_cnt_q + WEIGHT_WRITE_ADDR_WIDTH'(1);
            end
        end
    end

    weight_read_seq u_read_seq (
        .clk             (clk),
        .rst             (rst),
        .start_i         (seq_start),
        .ks_i            (ks_q),
        .num_slices_i    (num_slices_q),
        .out_ready_i     (out_ready),
        .ram_dout_i      (ram_dout),
        .ram_addr_read_o (ram_addr_read),
        .out_valid_o     (out_valid),
        .out_data_o      (out_data),
        .out_last_o      (out_last),
        .done_o          (seq_done)
    );

endmodule
